// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared RV32I decode constants, ID/EX payload type and immediate helper
package id_stage_pkg;

    localparam int PC_WIDTH = 10;

    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_I_IMM   = 7'b0010011;
    localparam logic [6:0] OP_R       = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic        illegal;
    } id_ex_t;

    // OP_R and unsupported opcodes carry a zero immediate.
    function automatic logic [31:0] gen_imm(input logic [31:0] inst);
        logic [31:0] imm;
        case (inst[6:0])
            OP_U_LUI, OP_U_AUIPC: imm = {inst[31:12], 12'b0};
            OP_I_IMM:             imm = {{20{inst[31]}}, inst[31:20]};
            default:              imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch-to-decode handshake bundle
interface id_stage_if import id_stage_pkg::*; #(
    parameter int PC_W = PC_WIDTH
);
    logic            if_valid;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     if_inst;
    logic            id_ready;

    modport master (
        output if_valid,
        output if_pc,
        output if_inst,
        input  id_ready
    );

    modport slave (
        input  if_valid,
        input  if_pc,
        input  if_inst,
        output id_ready
    );
endinterface

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - 32x32 register file, two bypassed read ports, one write port
module id_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] mem_q [32];
    logic        wr_en;

    assign wr_en = we_i && (waddr_i != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 32'b0;
            end
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle forwarding of the write port removes RAW stalls.
    always_comb begin
        rdata1_o = 32'b0;
        rdata2_o = 32'b0;
        if (raddr1_i != 5'd0) begin
            rdata1_o = (wr_en && waddr_i == raddr1_i) ? wdata_i : mem_q[raddr1_i];
        end
        if (raddr2_i != 5'd0) begin
            rdata2_o = (wr_en && waddr_i == raddr2_i) ? wdata_i : mem_q[raddr2_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode: field split, immediate, legality check, operand read, ID/EX register
module id_stage import id_stage_pkg::*; #(
    parameter int PC_W = PC_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    id_stage_if.slave       fetch,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [31:0]     wb_data_i,
    output logic            ex_valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [6:0]      opcode_o,
    output logic [6:0]      funct7_o,
    output logic [2:0]      funct3_o,
    output logic [31:0]     imm_o,
    output logic [31:0]     rs1_data_o,
    output logic [31:0]     rs2_data_o,
    output logic            rd_we_o,
    output logic [4:0]      rd_addr_o,
    output logic            illegal_o
);

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        legal;

    id_ex_t          stage_d, stage_q;
    logic [PC_W-1:0] pc_d, pc_q;

    assign inst     = fetch.if_inst;
    assign opcode   = inst[6:0];
    assign rd_addr  = inst[11:7];
    assign funct3   = inst[14:12];
    assign rs1_addr = inst[19:15];
    assign rs2_addr = inst[24:20];
    assign funct7   = inst[31:25];

    assign fetch.id_ready = !stall_i;

    id_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rs1_addr),
        .raddr2_i (rs2_addr),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data),
        .we_i     (wb_we_i),
        .waddr_i  (wb_addr_i),
        .wdata_i  (wb_data_i)
    );

    // EX only understands base-ISA funct7 values; anything else is trapped here.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_U_LUI, OP_U_AUIPC: legal = 1'b1;
            OP_I_IMM: begin
                if (funct3 == F3_SLL) begin
                    legal = (funct7 == F7_ZERO);
                end else if (funct3 == F3_SR) begin
                    legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                end else begin
                    legal = 1'b1;
                end
            end
            OP_R: begin
                legal = (funct7 == F7_ZERO) ||
                        ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        pc_d    = pc_q;
        if (flush_i) begin
            stage_d = '0;
            pc_d    = '0;
        end else if (!stall_i) begin
            if (fetch.if_valid && legal) begin
                stage_d.valid    = 1'b1;
                stage_d.opcode   = opcode;
                stage_d.funct7   = funct7;
                stage_d.funct3   = funct3;
                stage_d.imm      = gen_imm(inst);
                stage_d.rs1_data = rs1_data;
                stage_d.rs2_data = rs2_data;
                stage_d.rd_we    = (rd_addr != 5'd0);
                stage_d.rd_addr  = rd_addr;
                stage_d.illegal  = 1'b0;
                pc_d             = fetch.if_pc;
            end else begin
                stage_d         = '0;
                stage_d.illegal = fetch.if_valid;
                pc_d            = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            pc_q    <= '0;
        end else begin
            stage_q <= stage_d;
            pc_q    <= pc_d;
        end
    end

    assign ex_valid_o = stage_q.valid;
    assign pc_o       = pc_q;
    assign opcode_o   = stage_q.opcode;
    assign funct7_o   = stage_q.funct7;
    assign funct3_o   = stage_q.funct3;
    assign imm_o      = stage_q.imm;
    assign rs1_data_o = stage_q.rs1_data;
    assign rs2_data_o = stage_q.rs2_data;
    assign rd_we_o    = stage_q.rd_we;
    assign rd_addr_o  = stage_q.rd_addr;
    assign illegal_o  = stage_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage against a behavioural decode model
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        ex_valid_o;
    logic [9:0]  pc_o;
    logic [6:0]  opcode_o;
    logic [6:0]  funct7_o;
    logic [2:0]  funct3_o;
    logic [31:0] imm_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;
    logic        illegal_o;

    int total = 0;
    int bad = 0;

    id_stage_if #(.PC_W(10)) fif ();

    id_stage #(.PC_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch      (fif),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .ex_valid_o (ex_valid_o),
        .pc_o       (pc_o),
        .opcode_o   (opcode_o),
        .funct7_o   (funct7_o),
        .funct3_o   (funct3_o),
        .imm_o      (imm_o),
        .rs1_data_o (rs1_data_o),
        .rs2_data_o (rs2_data_o),
        .rd_we_o    (rd_we_o),
        .rd_addr_o  (rd_addr_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [9:0]  pc;
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        we;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    exp_t        cur = '0;
    logic [31:0] rf[32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic bit model_legal(input logic [31:0] w);
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        op = w[6:0];
        f7 = w[31:25];
        f3 = w[14:12];
        if (op == 7'h37 || op == 7'h17) return 1'b1;
        if (op == 7'h13) return !(f3 == 3'd1 && f7 != 7'h00) &&
                                !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        if (op == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return rf[a];
    endfunction

    task automatic drive(input bit v, input logic [31:0] w, input bit st, input bit fl,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [9:0] pc);
        exp_t n;
        @(negedge clk);
        fif.if_valid = v;
        fif.if_inst  = w;
        fif.if_pc    = pc;
        stall_i      = st;
        flush_i      = fl;
        wb_we_i      = we;
        wb_addr_i    = wa;
        wb_data_i    = wd;
        n = cur;
        if (fl) begin
            n = '0;
        end else if (!st) begin
            n = '0;
            if (v && model_legal(w)) begin
                n.v   = 1'b1;
                n.pc  = pc;
                n.op  = w[6:0];
                n.f7  = w[31:25];
                n.f3  = w[14:12];
                if (w[6:0] == 7'h13) n.imm = $unsigned($signed(w) >>> 20);
                else if (w[6:0] == 7'h33) n.imm = 32'h0;
                else n.imm = w & 32'hFFFF_F000;
                n.r1  = model_read(w[19:15], we, wa, wd);
                n.r2  = model_read(w[24:20], we, wa, wd);
                n.rd  = w[11:7];
                n.we  = (w[11:7] != 0);
            end else begin
                n.ill = v;
            end
        end
        cur = n;
        q.push_back(n);
        if (we && wa != 0) rf[wa] = wd;
        #1;
        chk("id_ready", {31'b0, fif.id_ready}, {31'b0, !st});
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int k;
        int j;
        w = $urandom;
        k = $urandom_range(0, 4);
        case (k)
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h13;
            3: w[6:0] = 7'h33;
            default: w[6:0] = 7'($urandom);
        endcase
        j = $urandom_range(0, 3);
        if (j < 2) w[31:25] = 7'h00;
        else if (j == 2) w[31:25] = 7'h20;
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 9) < 8, rand_inst(), $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 7, 1'($urandom), 5'($urandom_range(0, 7)),
                  $urandom, 10'($urandom));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, {31'b0, ex_valid_o}, 32'h0);
        chk({tag, "_pc"}, {22'b0, pc_o}, 32'h0);
        chk({tag, "_opcode"}, {25'b0, opcode_o}, 32'h0);
        chk({tag, "_funct7"}, {25'b0, funct7_o}, 32'h0);
        chk({tag, "_funct3"}, {29'b0, funct3_o}, 32'h0);
        chk({tag, "_imm"}, imm_o, 32'h0);
        chk({tag, "_rs1"}, rs1_data_o, 32'h0);
        chk({tag, "_rs2"}, rs2_data_o, 32'h0);
        chk({tag, "_rd_we"}, {31'b0, rd_we_o}, 32'h0);
        chk({tag, "_rd_addr"}, {27'b0, rd_addr_o}, 32'h0);
        chk({tag, "_illegal"}, {31'b0, illegal_o}, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_valid", {31'b0, ex_valid_o}, {31'b0, e.v});
                chk("sb_pc", {22'b0, pc_o}, {22'b0, e.pc});
                chk("sb_opcode", {25'b0, opcode_o}, {25'b0, e.op});
                chk("sb_funct7", {25'b0, funct7_o}, {25'b0, e.f7});
                chk("sb_funct3", {29'b0, funct3_o}, {29'b0, e.f3});
                chk("sb_imm", imm_o, e.imm);
                chk("sb_rs1", rs1_data_o, e.r1);
                chk("sb_rs2", rs2_data_o, e.r2);
                chk("sb_rd_we", {31'b0, rd_we_o}, {31'b0, e.we});
                chk("sb_rd_addr", {27'b0, rd_addr_o}, {27'b0, e.rd});
                chk("sb_illegal", {31'b0, illegal_o}, {31'b0, e.ill});
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        fif.if_valid = 1'b0;
        fif.if_inst  = '0;
        fif.if_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        #2 rst_n = 1'b1;

        drive(1, 32'h0050_0093, 0, 0, 0, 0, 0, 10'h004);
        settle();
        chk("addi_valid", {31'b0, ex_valid_o}, 32'h1);
        chk("addi_opcode", {25'b0, opcode_o}, 32'h13);
        chk("addi_funct3", {29'b0, funct3_o}, 32'h0);
        chk("addi_imm", imm_o, 32'h5);
        chk("addi_rs1", rs1_data_o, 32'h0);
        chk("addi_rd_we", {31'b0, rd_we_o}, 32'h1);
        chk("addi_rd_addr", {27'b0, rd_addr_o}, 32'h1);

        drive(1, 32'h0021_01B3, 0, 0, 1, 5'd2, 32'hDEAD_BEEF, 10'h008);
        settle();
        chk("bypass_rs1", rs1_data_o, 32'hDEAD_BEEF);
        chk("bypass_rs2", rs2_data_o, 32'hDEAD_BEEF);

        drive(0, 32'h0, 0, 0, 1, 5'd0, 32'h0000_1234, 10'h00C);
        drive(1, 32'h0000_0233, 0, 0, 0, 0, 0, 10'h010);
        settle();
        chk("x0_rs1", rs1_data_o, 32'h0);

        drive(1, 32'hABCD_E2B7, 0, 0, 0, 0, 0, 10'h014);
        settle();
        chk("lui_imm", imm_o, 32'hABCD_E000);
        chk("lui_rd", {27'b0, rd_addr_o}, 32'h5);

        drive(1, 32'h4030_D093, 0, 0, 0, 0, 0, 10'h018);
        settle();
        chk("srai_funct7", {25'b0, funct7_o}, 32'h20);
        chk("srai_imm", imm_o, 32'h0000_0403);

        drive(1, 32'h0010_0013, 0, 0, 0, 0, 0, 10'h01C);
        settle();
        chk("addi_x0_rd_we", {31'b0, rd_we_o}, 32'h0);

        drive(1, 32'h0220_81B3, 0, 0, 0, 0, 0, 10'h020);
        settle();
        chk("mul_valid", {31'b0, ex_valid_o}, 32'h0);
        chk("mul_opcode", {25'b0, opcode_o}, 32'h0);
        chk("mul_illegal", {31'b0, illegal_o}, 32'h1);
        drive(0, 32'h0, 0, 0, 0, 0, 0, 10'h024);
        settle();
        chk("mul_illegal_once", {31'b0, illegal_o}, 32'h0);

        drive(1, 32'h0000_0063, 0, 0, 0, 0, 0, 10'h028);
        settle();
        chk("branch_illegal", {31'b0, illegal_o}, 32'h1);
        chk("branch_valid", {31'b0, ex_valid_o}, 32'h0);

        drive(1, 32'h0050_0093, 0, 0, 0, 0, 0, 10'h02C);
        drive(1, 32'h0021_01B3, 1, 0, 1, 5'd1, 32'h5555_AAAA, 10'h030);
        drive(1, 32'hABCD_E2B7, 1, 0, 0, 0, 0, 10'h034);
        settle();
        chk("stall_hold_imm", imm_o, 32'h5);
        chk("stall_hold_pc", {22'b0, pc_o}, 32'h02C);

        drive(1, 32'h0050_0093, 1, 1, 0, 0, 0, 10'h038);
        settle();
        chk("flush_stall_valid", {31'b0, ex_valid_o}, 32'h0);

        drive(1, 32'h0220_81B3, 0, 1, 0, 0, 0, 10'h03C);
        settle();
        chk("flush_illegal", {31'b0, illegal_o}, 32'h0);

        rand_cycles(400);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fif.if_valid = 1'b1;
            fif.if_inst  = 32'h0050_0093;
            stall_i      = 1'b0;
            flush_i      = 1'b0;
            wb_we_i      = 1'b1;
            wb_addr_i    = 5'(i + 1);
            wb_data_i    = $urandom;
            @(posedge clk);
            #1;
            chk("rst_hold_valid", {31'b0, ex_valid_o}, 32'h0);
        end
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        cur = '0;
        wb_we_i = 1'b0;
        #2 rst_n = 1'b1;

        for (int i = 1; i < 32; i++) begin
            drive(1, {7'b0, 5'(i), 5'(i), 3'b0, 5'd1, 7'b0110011}, 0, 0, 0, 0, 0, 10'(i));
        end

        rand_cycles(300);

        drive(0, 32'h0, 0, 0, 0, 0, 0, 10'h0);
        settle();
        chk("queue_drained", q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
